// File: rtl/skew_load_ctrl.sv
// Skew load controller for a DIM x DIM systolic array.
// Accepts DIM column beats, scattering each element into its row's shift
// buffer at a position chosen so that row r is delayed by r cycles. It then
// shifts all buffers together for DEPTH cycles and pulses tile_done.
//
// Ports:
//   clk, rstn   rising-edge clock, asynchronous active-low reset
//   in_valid    column beat valid
//   in_ready    controller accepts a beat (LOAD state)
//   in_data     column beat, slice r is the element for buffer r
//   buf_load    per-buffer load enable (combinational from the accept)
//   buf_id      per-buffer load position, slice r for buffer r (combinational)
//   buf_data    per-buffer shift_in / load data (combinational)
//   buf_shift   shift enable common to all buffers
//   array_en    buffer outputs carry valid skewed data this cycle
//   tile_done   one-cycle pulse after the tile has fully streamed
//   step        current shift step, 0 outside SHIFT
module skew_load_ctrl #(
    parameter int unsigned N   = 8,
    parameter int unsigned DIM = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DIM*N-1:0]                in_data,
    output logic [DIM-1:0]                  buf_load,
    output logic [DIM*$clog2(2*DIM-1)-1:0]  buf_id,
    output logic [DIM*N-1:0]                buf_data,
    output logic                            buf_shift,
    output logic                            array_en,
    output logic                            tile_done,
    output logic [$clog2(2*DIM-1)-1:0]      step
);

    localparam int unsigned DEPTH = 2 * DIM - 1;
    localparam int unsigned IDW   = $clog2(DEPTH);
    localparam int unsigned BW    = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [BW-1:0]   beat;
    logic [BW-1:0]   next_beat;
    logic [IDW-1:0]  next_step;
    logic            accept;

    // in_ready is high exactly while in LOAD, so it doubles as the state decode
    assign accept = in_valid & in_ready;

    // State, beat counter and step counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= LOAD;
            beat  <= '0;
            step  <= '0;
        end else begin
            state <= next_state;
            beat  <= next_beat;
            step  <= next_step;
        end
    end

    // Next-state, beat and step sequencing
    always_comb begin
        next_state = state;
        next_beat  = beat;
        next_step  = step;
        case (state)
            LOAD: begin
                if (accept) begin
                    if (beat == BW'(DIM - 1)) begin
                        next_beat  = '0;
                        next_step  = '0;
                        next_state = SHIFT;
                    end else begin
                        next_beat = beat + BW'(1);
                    end
                end
            end
            SHIFT: begin
                if (step == IDW'(DEPTH - 1)) begin
                    next_step  = '0;
                    next_state = DONE;
                end else begin
                    next_step = step + IDW'(1);
                end
            end
            DONE: begin
                next_state = LOAD;
            end
            default: begin
                next_state = LOAD;
                next_beat  = '0;
                next_step  = '0;
            end
        endcase
    end

    // Registered status outputs, decoded from the upcoming state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_ready  <= 1'b1;
            buf_shift <= 1'b0;
            array_en  <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            in_ready  <= (next_state == LOAD);
            buf_shift <= (next_state == SHIFT);
            array_en  <= (next_state == SHIFT);
            tile_done <= (next_state == DONE);
        end
    end

    // Load scatter: element (r, beat) lands at DEPTH-1-r-beat so it leaves
    // the buffer output on shift step r+beat. Never positive in SHIFT/DONE,
    // so load and shift cannot coincide.
    always_comb begin
        buf_load = '0;
        buf_id   = '0;
        buf_data = '0;
        if (accept) begin
            buf_load = '1;
            buf_data = in_data;
            for (int unsigned r = 0; r < DIM; r++) begin
                buf_id[r*IDW +: IDW] = IDW'(DEPTH - 1 - r - 32'(beat));
            end
        end
    end

endmodule

// File: tb/tb_skew_load_ctrl.sv
module tb_skew_load_ctrl;

    localparam int N     = 8;
    localparam int DIM   = 4;
    localparam int DEPTH = 2 * DIM - 1;
    localparam int IDW   = 3;

    logic                 clk;
    logic                 rstn;
    logic                 in_valid;
    logic                 in_ready;
    logic [DIM*N-1:0]     in_data;
    logic [DIM-1:0]       buf_load;
    logic [DIM*IDW-1:0]   buf_id;
    logic [DIM*N-1:0]     buf_data;
    logic                 buf_shift;
    logic                 array_en;
    logic                 tile_done;
    logic [IDW-1:0]       step;

    skew_load_ctrl #(.N(N), .DIM(DIM)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .buf_load  (buf_load),
        .buf_id    (buf_id),
        .buf_data  (buf_data),
        .buf_shift (buf_shift),
        .array_en  (array_en),
        .tile_done (tile_done),
        .step      (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: tile contents, timeline position, modelled shift buffers
    logic [7:0] tile_load [DIM][DIM];   // [row][col] of tile being loaded
    logic [7:0] tile_cur  [DIM][DIM];   // [row][col] of tile being streamed
    logic [7:0] mem       [DIM][DEPTH]; // buffer r, position p (output at DEPTH-1)
    int ph        = -1;  // -1: loading, 0..DEPTH-1: shift step, DEPTH: done cycle
    int kb        = 0;   // beats accepted in current tile
    int auto_mode = 0;   // 0 pattern r*16+k, 1 random, 2 repeat previous
    int tiles     = 0;
    int low_run   = 0;
    int last_run  = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic gen_tile(input int mode);
        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++)
                if (mode == 0) tile_load[r][k] = 8'(r * 16 + k);
                else if (mode == 1) tile_load[r][k] = 8'($urandom);
    endtask

    task automatic clear_model();
        for (int r = 0; r < DIM; r++)
            for (int p = 0; p < DEPTH; p++)
                mem[r][p] = 8'h00;
        ph = -1;
        kb = 0;
    endtask

    // One clock: drive at negedge, check #1 later, advance the model
    task automatic cycle(input logic v);
        logic acc;
        logic shifting;
        logic [7:0] e;
        logic nz;
        int id;
        @(negedge clk);
        in_valid = v;
        in_data  = $urandom;
        if (v && ph < 0)
            for (int r = 0; r < DIM; r++) in_data[r*N +: N] = tile_load[r][kb];
        #1;
        acc      = v && (ph < 0);
        shifting = (ph >= 0) && (ph < DEPTH);
        chk("in_ready", 64'(in_ready), 64'(ph < 0));
        chk("buf_load", 64'(buf_load), acc ? 64'hF : 64'h0);
        for (int r = 0; r < DIM; r++)
            chk($sformatf("buf_id[%0d]", r), 64'(buf_id[r*IDW +: IDW]),
                acc ? 64'(DEPTH - 1 - r - kb) : 64'h0);
        chk("buf_data", 64'(buf_data), acc ? 64'(in_data) : 64'h0);
        chk("buf_shift", 64'(buf_shift), 64'(shifting));
        chk("array_en", 64'(array_en), 64'(shifting));
        chk("step", 64'(step), shifting ? 64'(ph) : 64'h0);
        chk("tile_done", 64'(tile_done), 64'(ph == DEPTH));
        chk("load_shift_excl", 64'((|buf_load) & buf_shift), 64'h0);
        chk("done_width", 64'(prev_done & tile_done), 64'h0);
        if (shifting)
            for (int r = 0; r < DIM; r++) begin
                e = (ph - r >= 0 && ph - r < DIM) ? tile_cur[r][ph - r] : 8'h00;
                chk($sformatf("buf_out[%0d] step%0d", r, ph), 64'(mem[r][DEPTH-1]), 64'(e));
            end
        if (ph == DEPTH) begin
            nz = 1'b0;
            for (int r = 0; r < DIM; r++)
                for (int p = 0; p < DEPTH; p++)
                    if (mem[r][p] != 8'h00) nz = 1'b1;
            chk("buf_clear_after_tile", 64'(nz), 64'h0);
        end
        prev_done = tile_done;
        if (!in_ready) low_run++;
        else if (low_run > 0) begin
            last_run = low_run;
            low_run  = 0;
        end
        // Buffers react to the controller's actual outputs
        for (int r = 0; r < DIM; r++) begin
            if (buf_load[r]) begin
                id = int'(buf_id[r*IDW +: IDW]);
                if (id < DEPTH) mem[r][id] = buf_data[r*N +: N];
            end
            if (buf_shift) begin
                for (int p = DEPTH - 1; p > 0; p--) mem[r][p] = mem[r][p-1];
                mem[r][0] = buf_data[r*N +: N];
            end
        end
        // Expected timeline
        if (acc) begin
            kb++;
            if (kb == DIM) begin
                kb = 0;
                ph = 0;
                tile_cur = tile_load;
                gen_tile(auto_mode);
            end
        end else if (shifting) begin
            ph++;
        end else if (ph == DEPTH) begin
            ph = -1;
            tiles++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ph >= 0 || kb != 0) && n < 40) begin
            cycle(1'b0);
            n++;
        end
        chk("idle_timeout", 64'(ph >= 0), 64'h0);
    endtask

    initial begin
        int t0;
        int n;
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clear_model();
        gen_tile(0);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_buf_shift", 64'(buf_shift), 64'h0);
        chk("rst_array_en", 64'(array_en), 64'h0);
        chk("rst_tile_done", 64'(tile_done), 64'h0);
        chk("rst_step", 64'(step), 64'h0);
        chk("rst_buf_load", 64'(buf_load), 64'h0);
        rstn = 1'b1;

        // Back-to-back beats with pattern data, then idle through stream
        auto_mode = 1;
        repeat (DIM) cycle(1'b1);
        wait_idle();

        // Gapped valid pattern
        cycle(1'b1); cycle(1'b0); cycle(1'b0); cycle(1'b1);
        cycle(1'b1); cycle(1'b0); cycle(1'b1);
        chk("gap_shift_started", 64'(ph), 64'h0);
        wait_idle();

        // Valid held high over two tiles carrying identical data
        gen_tile(1);
        auto_mode = 2;
        t0 = tiles;
        n  = 0;
        while (tiles < t0 + 2 && n < 60) begin
            cycle(1'b1);
            n++;
        end
        chk("two_tiles_done", 64'(tiles - t0), 64'h2);
        chk("ready_low_run", 64'(last_run), 64'h8);
        wait_idle();

        // Reset in the middle of SHIFT, then a clean tile
        gen_tile(0);
        auto_mode = 1;
        n = 0;
        while (ph != 3 && n < 30) begin
            cycle(1'b1);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'h1);
        chk("midrst_buf_shift", 64'(buf_shift), 64'h0);
        chk("midrst_array_en", 64'(array_en), 64'h0);
        chk("midrst_step", 64'(step), 64'h0);
        chk("midrst_tile_done", 64'(tile_done), 64'h0);
        clear_model();
        prev_done = 1'b0;
        low_run = 0;
        gen_tile(0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (DIM) cycle(1'b1);
        wait_idle();

        // Random valid and data
        auto_mode = 1;
        gen_tile(1);
        repeat (600) cycle(1'($urandom_range(0, 1)));
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
